muldiv_seq_ctrl: RTL

- Sequences the multi-cycle multiply/divide unit that sits beside the EX-stage ALU and owns the HI/LO result write.
- Accepts a mult/div from EX and times its latency with a down-counter.
- Interlocks HI/LO consumers in the ISS stage by stalling fetch/ISS and bubbling EX until the result is written.
- Its stall/flush outputs are OR-ed with the pipeline hazard unit's stall/flush outputs at the pipe registers.

---
 rtl/muldiv_seq_ctrl_pkg.sv | 14 +
 rtl/muldiv_seq_ctrl_sat_counter.sv | 36 +++
 rtl/muldiv_seq_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared definitions for the mult/div sequencer: state encoding and default
// latency / counter-width constants.
package muldiv_seq_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES = 4;
    localparam int MD_DIV_CYCLES  = 32;
    localparam int MD_CNT_W       = 6;

endpackage : muldiv_seq_ctrl_pkg

// File: rtl/muldiv_seq_ctrl_sat_counter.sv
// Parameterised saturating up-counter with increment enable and synchronous
// clear; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step only while below the all-ones ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/muldiv_seq_ctrl.sv
// Mult/div sequencer: starts the unit from EX, times its latency, pulses the
// HI/LO write and interlocks HI/LO consumers waiting in ISS.
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = MD_CNT_W,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              md_start_ex_i,
    input  logic              md_is_div_ex_i,
    input  logic              flush_ex_i,
    input  logic              hilo_use_iss_i,
    output logic              md_go_o,
    output logic              md_is_div_o,
    output logic              md_busy_o,
    output logic              hilo_wr_o,
    output logic              stall_fetch_o,
    output logic              stall_iss_o,
    output logic              flush_ex_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    // Counter is loaded with LAT-1 so that cnt == 0 marks the write cycle.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             accept_s;
    logic             done_s;
    logic             stall_s;

    // Accept, completion and interlock decode
    always_comb begin
        accept_s = md_start_ex_i & ~flush_ex_i & (state_q == MD_IDLE);
        done_s   = (state_q == MD_RUN) & (cnt_q == {CNT_W{1'b0}});
        stall_s  = hilo_use_iss_i & ((state_q == MD_RUN) | accept_s);
    end

    // Next-state and latency counter sequencing
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        case (state_q)
            MD_IDLE: begin
                if (accept_s) begin
                    state_d  = MD_RUN;
                    cnt_d    = md_is_div_ex_i ? DIV_LOAD : MULT_LOAD;
                    is_div_d = md_is_div_ex_i;
                end else begin
                    state_d  = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (done_s) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and op-type registers; reset abandons any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
        end
    end

    assign md_go_o       = accept_s;
    assign md_is_div_o   = is_div_q;
    assign md_busy_o     = (state_q == MD_RUN);
    assign hilo_wr_o     = done_s;
    assign stall_fetch_o = stall_s;
    assign stall_iss_o   = stall_s;
    assign flush_ex_o    = stall_s;

    sat_counter #(
        .W (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (stall_s),
        .cnt_o (stall_cnt_o)
    );

endmodule : muldiv_seq_ctrl
